// File: rtl/picosoc_timer_if.sv
// picosoc_timer_if: iomem bus bundle between the SoC iomem port and the timer.
//   iomem_valid  request, held by the master until acknowledged
//   iomem_ready  one-cycle acknowledge from the slave
//   iomem_wstrb  byte write strobes, 4'b0000 means read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid only while iomem_ready is high (0 otherwise)
interface picosoc_timer_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic                iomem_valid;
    logic                iomem_ready;
    logic [STRB_W-1:0]   iomem_wstrb;
    logic [ADDR_W-1:0]   iomem_addr;
    logic [DATA_W-1:0]   iomem_wdata;
    logic [DATA_W-1:0]   iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );
endinterface

// File: rtl/picosoc_timer.sv
// picosoc_timer: down-counting timer peripheral with 16-bit prescaler,
// one-shot / auto-reload modes and a level interrupt.
//   clk    single clock, all state on the rising edge
//   reset  asynchronous, active-high
//   bus    iomem slave port (256-byte window at BASE_ADDR)
//   irq    registered level interrupt = STATUS.expired & CTRL.irq_en
// Register map (offset = addr[7:2]):
//   0x00 CTRL     bit0 enable, bit1 auto_reload, bit2 irq_en
//   0x04 PRESCALE [15:0]
//   0x08 LOAD     [31:0]
//   0x0C COUNT    [31:0]
//   0x10 STATUS   bit0 expired, write-1-to-clear
module picosoc_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    picosoc_timer_if.slave bus,
    output logic           irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PRE_W  = 16;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned OFF_W  = 6;

    localparam logic [OFF_W-1:0] OFF_CTRL     = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_PRESCALE = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_LOAD     = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_COUNT    = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_STATUS   = OFF_W'(4);

    // CTRL bit positions
    localparam int unsigned B_EN   = 0;
    localparam int unsigned B_AUTO = 1;
    localparam int unsigned B_IRQE = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    state_e              state_q;
    logic                ready_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [CTRL_W-1:0]   ctrl_q,     ctrl_d;
    logic [PRE_W-1:0]    prescale_q, prescale_d;
    logic [PRE_W-1:0]    pcnt_q,     pcnt_d;
    logic [DATA_W-1:0]   load_q,     load_d;
    logic [DATA_W-1:0]   count_q,    count_d;
    logic                expired_q,  expired_d;
    logic                irq_q;

    logic [OFF_W-1:0]    off_c;
    logic                sel_c;
    logic                wr_c;
    logic                tick_c;
    logic                expire_c;
    logic                clr_c;
    logic [DATA_W-1:0]   rd_mux_c;
    logic                unused_addr_c;

    // Byte-lane merge of new write data over an old register value.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [3:0]        strb
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Address decode; bus writes only happen on the IDLE->ACK capture edge.
    always_comb begin
        off_c = bus.iomem_addr[7:2];
        sel_c = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
        wr_c  = sel_c && (state_q == ST_IDLE) && (bus.iomem_wstrb != 4'b0000);
    end

    assign unused_addr_c = ^bus.iomem_addr[1:0];

    // Read mux over the current register values.
    always_comb begin
        rd_mux_c = '0;
        case (off_c)
            OFF_CTRL:     rd_mux_c = {(DATA_W-CTRL_W)'(0), ctrl_q};
            OFF_PRESCALE: rd_mux_c = {(DATA_W-PRE_W)'(0), prescale_q};
            OFF_LOAD:     rd_mux_c = load_q;
            OFF_COUNT:    rd_mux_c = count_q;
            OFF_STATUS:   rd_mux_c = {(DATA_W-1)'(0), expired_q};
            default:      rd_mux_c = '0;
        endcase
    end

    // Timer datapath: hardware update first, bus write applied on top so it wins.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        load_d     = load_q;
        count_d    = count_q;
        expire_c   = 1'b0;
        clr_c      = 1'b0;

        tick_c = ctrl_q[B_EN] && (pcnt_q == prescale_q);
        if (ctrl_q[B_EN]) begin
            pcnt_d = tick_c ? '0 : pcnt_q + PRE_W'(1);
        end else begin
            pcnt_d = '0;
        end

        if (tick_c) begin
            if (count_q != '0) begin
                count_d = count_q - DATA_W'(1);
            end else begin
                expire_c = 1'b1;
                if (ctrl_q[B_AUTO]) count_d = load_q;
                else                ctrl_d[B_EN] = 1'b0;
            end
        end

        if (wr_c) begin
            case (off_c)
                OFF_CTRL: begin
                    if (bus.iomem_wstrb[0]) ctrl_d = bus.iomem_wdata[CTRL_W-1:0];
                end
                OFF_PRESCALE: begin
                    if (bus.iomem_wstrb[0]) prescale_d[7:0]  = bus.iomem_wdata[7:0];
                    if (bus.iomem_wstrb[1]) prescale_d[15:8] = bus.iomem_wdata[15:8];
                end
                OFF_LOAD:   load_d  = byte_merge(load_q, bus.iomem_wdata, bus.iomem_wstrb);
                OFF_COUNT:  count_d = byte_merge(count_d, bus.iomem_wdata, bus.iomem_wstrb);
                OFF_STATUS: clr_c   = bus.iomem_wstrb[0] && bus.iomem_wdata[0];
                default: ;
            endcase
        end

        // Expiry on the same edge as a clear keeps the flag set.
        expired_d = expire_c | (expired_q & ~clr_c);
    end

    // Bus handshake FSM with registered ready/rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                    if (sel_c) begin
                        state_q <= ST_ACK;
                        ready_q <= 1'b1;
                        rdata_q <= rd_mux_c;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    // Register file, prescaler and interrupt register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            prescale_q <= PRESCALE_RESET;
            pcnt_q     <= '0;
            load_q     <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            irq_q      <= expired_q & ctrl_q[B_IRQE];
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_picosoc_timer.sv
// tb_picosoc_timer: self-checking bench for picosoc_timer. Reads push their
// expected data into a scoreboard queue, which is popped when the ack arrives.
module tb_picosoc_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_LOAD = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    picosoc_timer_if bus ();

    picosoc_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    // One bus access; returns whether/when it was acked and the read data.
    task automatic xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                        output logic got, output int lat, output logic [31:0] rd, output int ack_cyc);
        got = 1'b0; lat = 0; rd = '0; ack_cyc = -1;
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = wdata;
        for (int i = 1; i <= 6 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.iomem_ready === 1'b1) begin
                got = 1'b1; lat = i; rd = bus.iomem_rdata; ack_cyc = cyc;
            end
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                      output int ack_cyc);
        logic g; int l; logic [31:0] r;
        xfer(addr, strb, data, g, l, r, ack_cyc);
    endtask

    // Cycle number at which irq first equals lvl, or -1 if not within max cycles.
    task automatic wait_irq(input logic lvl, input int max, output int at);
        at = -1;
        for (int i = 0; i < max && at < 0; i++) begin
            @(posedge clk); #1;
            if (irq === lvl) at = cyc;
        end
    endtask

    task automatic test_reset;
        logic g; int l, a; logic [31:0] r, e;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.iomem_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.iomem_ready); end
        total++; if (bus.iomem_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.iomem_rdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'h0);
        xfer(A_LOAD, 4'h0, 32'h0, g, l, r, a);
        e = exp_q.pop_front();
        total++; if (g !== 1'b1 || l != 1) begin bad++; $display("FAIL rst_read_lat: got ack=%b lat=%0d want ack=1 lat=1", g, l); end
        total++; if (r !== e) begin bad++; $display("FAIL rst_read_load: got %h want %h", r, e); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq_after_read: got %b want 0", irq); end
    endtask

    task automatic test_auto_reload;
        int w, c, at; logic g; int l, a; logic [31:0] r, e;
        wr(A_LOAD, 4'hF, 32'd4, c);
        wr(A_PRE,  4'hF, 32'd1, c);
        wr(A_CNT,  4'hF, 32'd4, c);
        wr(A_CTRL, 4'hF, 32'h7, w);
        wait_irq(1'b1, 40, at);
        total++; if (at != w + 11) begin bad++; $display("FAIL auto_first_irq: got cycle %0d want %0d", at, w + 11); end
        wr(A_STAT, 4'h1, 32'h1, c);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL auto_clear_irq: got %b want 0", irq); end
        wait_irq(1'b1, 40, at);
        total++; if (at != w + 21) begin bad++; $display("FAIL auto_second_irq: got cycle %0d want %0d", at, w + 21); end
        exp_q.push_back(32'd4);
        xfer(A_CNT, 4'h0, 32'h0, g, l, r, a);
        e = exp_q.pop_front();
        total++; if (r !== e) begin bad++; $display("FAIL auto_count_reload: got %h want %h", r, e); end
        wr(A_CTRL, 4'hF, 32'h0, c);
        wr(A_STAT, 4'h1, 32'h1, c);
    endtask

    task automatic test_one_shot;
        int w, c, at; logic g; int l, a; logic [31:0] r, e;
        logic [31:0] addrs [3];
        logic [31:0] wants [3];
        wr(A_PRE,  4'hF, 32'd0, c);
        wr(A_CNT,  4'hF, 32'd2, c);
        wr(A_CTRL, 4'hF, 32'h5, w);
        wait_irq(1'b1, 20, at);
        total++; if (at != w + 4) begin bad++; $display("FAIL oneshot_irq: got cycle %0d want %0d", at, w + 4); end
        addrs[0] = A_CTRL; wants[0] = 32'h4;
        addrs[1] = A_CNT;  wants[1] = 32'h0;
        addrs[2] = A_STAT; wants[2] = 32'h1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(wants[i]);
            xfer(addrs[i], 4'h0, 32'h0, g, l, r, a);
            e = exp_q.pop_front();
            total++; if (r !== e) begin bad++; $display("FAIL oneshot_read%0d: got %h want %h", i, r, e); end
        end
        wr(A_STAT, 4'h1, 32'h1, c);
        wait_irq(1'b1, 20, at);
        total++; if (at != -1) begin bad++; $display("FAIL oneshot_no_refire: got cycle %0d want none", at); end
        exp_q.push_back(32'h0);
        xfer(A_CNT, 4'h0, 32'h0, g, l, r, a);
        e = exp_q.pop_front();
        total++; if (r !== e) begin bad++; $display("FAIL oneshot_count_hold: got %h want %h", r, e); end
    endtask

    task automatic test_byte_write;
        int c; logic g; int l, a; logic [31:0] r, e;
        wr(A_LOAD, 4'hF, 32'h1122_3344, c);
        wr(A_LOAD, 4'b0010, 32'hAABB_CCDD, c);
        exp_q.push_back(32'h1122_CC44);
        xfer(A_LOAD, 4'h0, 32'h0, g, l, r, a);
        e = exp_q.pop_front();
        total++; if (r !== e) begin bad++; $display("FAIL byte_load: got %h want %h", r, e); end
        wr(A_PRE, 4'hF, 32'hFFFF_FFFF, c);
        exp_q.push_back(32'h0000_FFFF);
        xfer(A_PRE, 4'h0, 32'h0, g, l, r, a);
        e = exp_q.pop_front();
        total++; if (r !== e) begin bad++; $display("FAIL prescale_width: got %h want %h", r, e); end
        wr(A_PRE, 4'hF, 32'h0, c);
    endtask

    task automatic test_same_edge_clear;
        int w, c;
        wr(A_PRE,  4'hF, 32'd0, c);
        wr(A_LOAD, 4'hF, 32'd5, c);
        wr(A_CNT,  4'hF, 32'd0, c);
        wr(A_CTRL, 4'hF, 32'h7, w);
        // expiries land on w+1, w+7, w+13 ...; aim the clear at w+7
        while (cyc < w + 6) begin @(posedge clk); #1; end
        wr(A_STAT, 4'h1, 32'h1, c);
        total++; if (c != w + 7) begin bad++; $display("FAIL same_edge_ack: got cycle %0d want %0d", c, w + 7); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL same_edge_irq: got %b want 1", irq); end
        wr(A_STAT, 4'h1, 32'h1, c);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL late_clear_irq: got %b want 0", irq); end
        wr(A_CTRL, 4'hF, 32'h0, c);
        wr(A_STAT, 4'h1, 32'h1, c);
    endtask

    task automatic test_decode;
        int c; logic g; int l, a; logic [31:0] r, e;
        xfer(32'h0400_0000, 4'h0, 32'h0, g, l, r, a);
        total++; if (g !== 1'b0) begin bad++; $display("FAIL foreign_read_ack: got %b want 0", g); end
        xfer(32'h0400_0008, 4'hF, 32'hDEAD_BEEF, g, l, r, a);
        total++; if (g !== 1'b0) begin bad++; $display("FAIL foreign_write_ack: got %b want 0", g); end
        exp_q.push_back(32'd5);
        xfer(A_LOAD, 4'h0, 32'h0, g, l, r, a);
        e = exp_q.pop_front();
        total++; if (r !== e) begin bad++; $display("FAIL foreign_write_dropped: got %h want %h", r, e); end
        wr(BASE + 32'h20, 4'hF, 32'hFFFF_FFFF, c);
        exp_q.push_back(32'h0);
        xfer(BASE + 32'h20, 4'h0, 32'h0, g, l, r, a);
        e = exp_q.pop_front();
        total++; if (g !== 1'b1 || l != 1) begin bad++; $display("FAIL hole_ack: got ack=%b lat=%0d want ack=1 lat=1", g, l); end
        total++; if (r !== e) begin bad++; $display("FAIL hole_rdata: got %h want %h", r, e); end
    endtask

    task automatic test_reset_mid;
        int c; logic g; int l, a; logic [31:0] r, e;
        logic [31:0] addrs [5];
        wr(A_LOAD, 4'hF, 32'h55, c);
        wr(A_CNT,  4'hF, 32'h66, c);
        wr(A_PRE,  4'hF, 32'h77, c);
        wr(A_CTRL, 4'hF, 32'h6, c);
        // reset between valid and the capture edge
        @(negedge clk);
        bus.iomem_valid = 1'b1; bus.iomem_addr = A_LOAD; bus.iomem_wstrb = 4'h0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.iomem_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready: got %b want 0", bus.iomem_ready); end
        @(negedge clk);
        reset = 1'b0; bus.iomem_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.iomem_ready !== 1'b0) begin bad++; $display("FAIL midreset_no_late_ack: got %b want 0", bus.iomem_ready); end
        // reset during the ack cycle
        @(negedge clk);
        bus.iomem_valid = 1'b1; bus.iomem_addr = A_CTRL;
        @(posedge clk); #1;
        total++; if (bus.iomem_ready !== 1'b1) begin bad++; $display("FAIL ackreset_pre: got %b want 1", bus.iomem_ready); end
        #1 reset = 1'b1;
        #1;
        total++; if (bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0) begin
            bad++; $display("FAIL ackreset_drop: got ready=%b rdata=%h want 0/0", bus.iomem_ready, bus.iomem_rdata);
        end
        @(negedge clk);
        reset = 1'b0; bus.iomem_valid = 1'b0;
        addrs[0] = A_CTRL; addrs[1] = A_PRE; addrs[2] = A_LOAD; addrs[3] = A_CNT; addrs[4] = A_STAT;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'h0);
            xfer(addrs[i], 4'h0, 32'h0, g, l, r, a);
            e = exp_q.pop_front();
            total++; if (r !== e) begin bad++; $display("FAIL midreset_reg%0d: got %h want %h", i, r, e); end
        end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", irq); end
    endtask

    initial begin
        reset = 1'b1;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_byte_write();
        test_same_edge_clear();
        test_decode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
